fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling FIFO between the instruction-fetch stage and the decode stage. It captures {PC, instruction} pairs from fetch, holds up to DEPTH of them, and presents the oldest to decode with a valid/ready handshake. Backpressure goes upstream as the fetch-stage freeze. A taken branch flushes all wrong-path entries in one cycle.

## Interface
- WORD_WIDTH, default `WORD_WIDTH (32): width of PC and instruction fields
- DEPTH, default 4: entry count; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  Branch_Taken from execute; synchronous discard of all entries
- in_valid  in  1  fetch presents a pair this cycle
- in_pc  in  WORD_WIDTH  PC value from fetch (PC_Stage_out)
- in_instruction  in  WORD_WIDTH  fetched instruction word
- in_ready  out  1  queue accepts a push this cycle; fetch Freeze is driven from ~in_ready (OR'd with hazard freeze outside this block)
- out_valid  out  1  head entry valid
- out_pc  out  WORD_WIDTH  head PC
- out_instruction  out  WORD_WIDTH  head instruction
- out_ready  in  1  decode consumes head this cycle (low while decode is frozen by hazard)
- count  out  clog2(DEPTH)+1  occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc, instruction}; write pointer wr_ptr and read pointer rd_ptr, each clog2(DEPTH) bits, wrap modulo DEPTH with no explicit compare.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Combinational from registered count only, with no dependence on out_ready, so a full queue does not accept a push in the same cycle as a pop.
- out_valid = (count != 0). out_pc and out_instruction show the head entry when valid and are driven to 0 when empty.
- Edge update, evaluated in priority order:
  - flush: count, wr_ptr and rd_ptr go to 0. Push and pop in the same cycle are ignored, so the incoming pair is dropped.
  - push only: write the pair at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count−1.
  - push & pop (only possible when 0<count<DEPTH): write at wr_ptr and advance both pointers; count is unchanged.
- No bypass: a pair pushed into an empty queue is visible on out_* after the next edge, never in the same cycle.
- Push while full cannot occur because in_ready is low. Pop while empty cannot occur because out_valid is low. No error flag is needed.
- Entry ordering is strict FIFO, including across pointer wrap.

## Timing
- Reset (rst low, asynchronous):
  - count=0, wr_ptr=rd_ptr=0
  - out_valid=0, out_pc=0, out_instruction=0, in_ready=1
  - Storage contents need not be cleared, because the zero mux on empty covers out_*.
- Reset release is synchronised outside this block. The first push is accepted on the first rising edge with rst high.
- Latency push→out_valid: 1 cycle. Throughput: 1 pair/cycle sustained when 0<count<DEPTH and out_ready=1.
- Flush takes effect at the edge. From the next cycle: out_valid=0, in_ready=1, count=0. The post-branch fetch is pushed on that cycle.
- Reset asserted mid-operation overrides everything immediately (asynchronous), including an in-flight flush.

## Structure
- WORD_WIDTH comes from the shared constants header; no new typedefs.
- A {pc, instruction} entry width of 2*WORD_WIDTH is a local parameter.
- Single module with inline storage array, pointers and counter; no sub-module.
- Top-level wiring:
  - in_pc/in_instruction connect from the fetch stage outputs.
  - out_* replace the plain fetch/decode pipeline register inputs to decode.

## Test plan
- Reset and fill:
  - Stimulus: rst low, then push PCs 1,2,3,4 with out_ready=0.
  - Required: out_valid=1 with out_pc=1 after the first push; count reaches 4; in_ready=0; a fifth in_valid with PC 5 is not stored.
- Drain order:
  - Stimulus: from full, out_ready=1 for 4 cycles.
  - Required: out_pc sequence 1,2,3,4; then out_valid=0, out_pc=0, out_instruction=0, count=0.
- Streaming with wrap:
  - Stimulus: in_valid=out_ready=1 for 10 cycles, PCs 10..19.
  - Required: count holds at 1 after the first edge; out_pc lags in_pc by exactly one cycle across pointer wrap.
- Flush priority:
  - Stimulus: count=3, then flush=1 with in_valid=1 (PC 0x40) and out_ready=1 in the same cycle.
  - Required: next cycle count=0, out_valid=0, in_ready=1; PC 0x40 never appears on out_pc.
- Full with simultaneous pop:
  - Stimulus: count=4, out_ready=1, in_valid=1.
  - Required: the pop occurs, the push is refused, count=3; in_ready=1 on the following cycle.
- Asynchronous reset mid-stream:
  - Stimulus: count=2; drop rst between clock edges.
  - Required: out_valid, out_pc and count go to 0 without waiting for clk.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch/decode decoupling queue.
// Word width matches the core-wide PC and instruction width.
package fetch_queue_pkg;

    localparam int unsigned DEFAULT_WORD_WIDTH = 32;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// FIFO between fetch and decode: holds {pc, instruction} pairs,
// applies backpressure via in_ready and drops everything on a taken branch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WORD_WIDTH-1:0]      in_pc,
    input  logic [WORD_WIDTH-1:0]      in_instruction,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WORD_WIDTH-1:0]      out_pc,
    output logic [WORD_WIDTH-1:0]      out_instruction,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned ENTRY_W = 2 * WORD_WIDTH;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // in_ready looks only at registered occupancy, so full never
    // accepts a push even when decode pops in the same cycle.
    assign in_ready  = (count != CNT_MAX);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head            = mem[rd_ptr];
    assign out_pc          = out_valid ? head[ENTRY_W-1:WORD_WIDTH] : '0;
    assign out_instruction = out_valid ? head[WORD_WIDTH-1:0]       : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    count  <= count + CNT_ONE;
                end
                2'b01: begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    count  <= count - CNT_ONE;
                end
                2'b11: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; the empty-queue zero mux hides stale data.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {in_pc, in_instruction};
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int W = 32;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_pc = '0;
    logic [W-1:0]  in_instruction = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_instruction;
    logic          out_ready = 1'b0;
    logic [2:0]    count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] ins;
    } pair_t;

    pair_t model[$];

    fetch_queue #(.WORD_WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_pc(in_pc),
        .in_instruction(in_instruction),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_instruction(out_instruction),
        .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ins_of(input logic [W-1:0] pc);
        return pc ^ 32'hA5C3_0F00;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = model.size();
        check("count", 64'(count), 64'(n));
        check("out_valid", 64'(out_valid), 64'(n != 0));
        check("in_ready", 64'(in_ready), 64'(n != D));
        check("out_pc", 64'(out_pc), n != 0 ? 64'(model[0].pc) : 64'd0);
        check("out_ins", 64'(out_instruction),
              n != 0 ? 64'(model[0].ins) : 64'd0);
    endtask

    // One clock: drive at negedge, check at negedge+1, update model at posedge.
    task automatic cycle(input logic fl, input logic iv,
                         input logic [W-1:0] pc, input logic [W-1:0] ins,
                         input logic ordy,
                         output logic [W-1:0] o_pc,
                         output logic [2:0] o_cnt,
                         output logic o_rdy);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        flush = fl;
        in_valid = iv;
        in_pc = pc;
        in_instruction = ins;
        out_ready = ordy;
        #1;
        check_outputs();
        o_pc = out_pc;
        o_cnt = count;
        o_rdy = in_ready;
        do_push = iv && (model.size() < D);
        do_pop = ordy && (model.size() > 0);
        @(posedge clk);
        if (fl) begin
            model.delete();
        end else begin
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back('{pc: pc, ins: ins});
        end
    endtask

    initial begin
        logic [W-1:0] opc;
        logic [2:0]   ocnt;
        logic         ordy_o;
        logic [W-1:0] rpc;

        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_ins", 64'(out_instruction), 64'd0);
        rst = 1'b1;

        // Fill with PCs 1..4, decode stalled
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, W'(i), ins_of(W'(i)), 0, opc, ocnt, ordy_o);
            if (i == 2) check("fill_head_pc", 64'(opc), 64'd1);
        end
        cycle(0, 1, 32'd5, ins_of(32'd5), 0, opc, ocnt, ordy_o);
        check("fill_count", 64'(ocnt), 64'd4);
        check("fill_ready", 64'(ordy_o), 64'd0);

        // Drain in order
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, '0, '0, 1, opc, ocnt, ordy_o);
            check("drain_pc", 64'(opc), 64'(i));
        end
        cycle(0, 0, '0, '0, 0, opc, ocnt, ordy_o);
        check("drain_empty_cnt", 64'(ocnt), 64'd0);
        check("drain_empty_pc", 64'(opc), 64'd0);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, W'(10 + i), ins_of(W'(10 + i)), 1, opc, ocnt, ordy_o);
            if (i > 0) begin
                check("stream_cnt", 64'(ocnt), 64'd1);
                check("stream_pc", 64'(opc), 64'(10 + i - 1));
            end
        end

        // Flush priority from count=3
        cycle(0, 1, 32'd20, ins_of(32'd20), 0, opc, ocnt, ordy_o);
        cycle(0, 1, 32'd21, ins_of(32'd21), 0, opc, ocnt, ordy_o);
        cycle(1, 1, 32'h40, ins_of(32'h40), 1, opc, ocnt, ordy_o);
        check("flush_pre_cnt", 64'(ocnt), 64'd3);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, '0, 1, opc, ocnt, ordy_o);
            check("flush_cnt", 64'(ocnt), 64'd0);
            check("flush_ready", 64'(ordy_o), 64'd1);
            check("flush_no40", 64'(opc == 32'h40), 64'd0);
        end

        // Full with simultaneous pop: push refused
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, W'(32'h100 + i), ins_of(W'(32'h100 + i)), 0,
                  opc, ocnt, ordy_o);
        end
        cycle(0, 1, 32'h1FF, ins_of(32'h1FF), 1, opc, ocnt, ordy_o);
        check("fullpop_pre_cnt", 64'(ocnt), 64'd4);
        cycle(0, 0, '0, '0, 1, opc, ocnt, ordy_o);
        check("fullpop_cnt", 64'(ocnt), 64'd3);
        check("fullpop_ready", 64'(ordy_o), 64'd1);
        check("fullpop_head", 64'(opc), 64'h101);

        // Now count=2; async reset between edges
        @(negedge clk);
        flush = 0;
        in_valid = 0;
        out_ready = 0;
        #1;
        check("arst_pre_cnt", 64'(count), 64'd2);
        #1;
        rst = 1'b0;
        #1;
        check("arst_cnt", 64'(count), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_pc", 64'(out_pc), 64'd0);
        model.delete();
        @(negedge clk);
        rst = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rpc = $urandom;
            cycle(($urandom_range(15) == 0), $urandom_range(1), rpc,
                  $urandom, $urandom_range(1), opc, ocnt, ordy_o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_queue
